// File: rtl/bp_be_dcache_mem_model_if.sv
// Memory command/response bundle between the D$ test wrapper and its backing memory model.
// Signal names are written from the memory model's point of view.
interface bp_be_dcache_mem_model_if #(
    parameter int unsigned mem_msg_width_p = 575
);
    logic [mem_msg_width_p-1:0] mem_cmd_i;
    logic                       mem_cmd_v_i;
    logic                       mem_cmd_ready_o;
    logic [mem_msg_width_p-1:0] mem_resp_o;
    logic                       mem_resp_v_o;
    logic                       mem_resp_yumi_i;

    modport slave (
        input  mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
        output mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
    );

    modport master (
        output mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
        input  mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
    );
endinterface

// File: rtl/bp_be_dcache_mem_model.sv
// Single-outstanding block memory responder: accept one command, wait latency_p cycles,
// then present the response until the consumer yumis it.
module bp_be_dcache_mem_model #(
    parameter int unsigned paddr_width_p   = 40,
    parameter int unsigned payload_width_p = 16,
    parameter int unsigned block_width_p   = 512,
    parameter int unsigned mem_els_p       = 1024,
    parameter int unsigned latency_p       = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    bp_be_dcache_mem_model_if.slave        mem_if,
    output logic [31:0]                    rd_count_o,
    output logic [31:0]                    wr_count_o
);
    localparam int unsigned mem_msg_width_lp = 4 + paddr_width_p + 3 + payload_width_p
                                               + block_width_p;
    localparam int unsigned offset_width_lp  = $clog2(block_width_p / 8);
    localparam int unsigned index_width_lp   = $clog2(mem_els_p);
    localparam int unsigned size_lsb_lp      = 4 + paddr_width_p;
    localparam int unsigned payload_lsb_lp   = size_lsb_lp + 3;
    localparam int unsigned data_lsb_lp      = payload_lsb_lp + payload_width_p;
    localparam int unsigned cnt_width_lp     = (latency_p > 1) ? $clog2(latency_p) : 1;

    typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

    state_e                        state_q, state_d;
    logic [cnt_width_lp-1:0]       cnt_q, cnt_d;
    logic [3:0]                    hdr_type_q, hdr_type_d;
    logic [paddr_width_p-1:0]      hdr_addr_q, hdr_addr_d;
    logic [2:0]                    hdr_size_q, hdr_size_d;
    logic [payload_width_p-1:0]    hdr_payload_q, hdr_payload_d;
    logic [mem_msg_width_lp-1:0]   resp_q, resp_d;
    logic [31:0]                   rd_count_q, rd_count_d, wr_count_q, wr_count_d;

    logic [block_width_p-1:0]      mem_q [mem_els_p];

    logic                          cmd_fire, mem_we;
    logic [3:0]                    cmd_type;
    logic [paddr_width_p-1:0]      cmd_addr;
    logic [2:0]                    cmd_size;
    logic [block_width_p-1:0]      cmd_data, cmd_mask, mem_wdata;
    logic [index_width_lp-1:0]     cmd_idx, rd_idx;
    logic [offset_width_lp-1:0]    cmd_off, rd_off;
    logic [2:0]                    rd_size;
    logic [block_width_p-1:0]      rd_block, resp_data;
    logic                          resp_is_wr;

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > 3'(offset_width_lp)) ? 3'(offset_width_lp) : size;
    endfunction

    function automatic logic [offset_width_lp-1:0] align_off(
        input logic [offset_width_lp-1:0] off, input logic [2:0] size);
        return off & ({offset_width_lp{1'b1}} << size);
    endfunction

    function automatic logic [block_width_p-1:0] low_mask(input logic [2:0] size);
        return {block_width_p{1'b1}} >> (block_width_p - (32'd8 << size));
    endfunction

    // Writes commit on the accepting edge, so the byte merge reads the array combinationally.
    always_comb begin
        cmd_fire  = mem_if.mem_cmd_v_i && (state_q == e_ready);
        cmd_type  = mem_if.mem_cmd_i[3:0];
        cmd_addr  = mem_if.mem_cmd_i[4 +: paddr_width_p];
        cmd_size  = clamp_size(mem_if.mem_cmd_i[size_lsb_lp +: 3]);
        cmd_data  = mem_if.mem_cmd_i[data_lsb_lp +: block_width_p];
        cmd_idx   = cmd_addr[offset_width_lp +: index_width_lp];
        cmd_off   = align_off(cmd_addr[offset_width_lp-1:0], cmd_size);
        cmd_mask  = low_mask(cmd_size) << {cmd_off, 3'b000};
        mem_we    = 1'b0;
        mem_wdata = mem_q[cmd_idx];
        if (cmd_fire && cmd_type == 4'd1) begin
            mem_we    = 1'b1;
            mem_wdata = cmd_data;
        end else if (cmd_fire && cmd_type == 4'd3) begin
            mem_we    = 1'b1;
            mem_wdata = (mem_q[cmd_idx] & ~cmd_mask) | ((cmd_data << {cmd_off, 3'b000}) & cmd_mask);
        end
    end

    always_comb begin
        rd_idx     = hdr_addr_q[offset_width_lp +: index_width_lp];
        rd_size    = clamp_size(hdr_size_q);
        rd_off     = align_off(hdr_addr_q[offset_width_lp-1:0], rd_size);
        rd_block   = mem_q[rd_idx];
        resp_is_wr = (hdr_type_q == 4'd1) || (hdr_type_q == 4'd3);
        unique case (hdr_type_q)
            4'd0:       resp_data = rd_block;
            4'd1, 4'd3: resp_data = '0;
            default:    resp_data = (rd_block >> {rd_off, 3'b000}) & low_mask(rd_size);
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hdr_type_d    = hdr_type_q;
        hdr_addr_d    = hdr_addr_q;
        hdr_size_d    = hdr_size_q;
        hdr_payload_d = hdr_payload_q;
        resp_d        = resp_q;
        rd_count_d    = rd_count_q;
        wr_count_d    = wr_count_q;
        unique case (state_q)
            e_ready: begin
                if (mem_if.mem_cmd_v_i) begin
                    hdr_type_d    = cmd_type;
                    hdr_addr_d    = cmd_addr;
                    hdr_size_d    = mem_if.mem_cmd_i[size_lsb_lp +: 3];
                    hdr_payload_d = mem_if.mem_cmd_i[payload_lsb_lp +: payload_width_p];
                    cnt_d         = cnt_width_lp'(latency_p - 1);
                    state_d       = e_wait;
                end
            end
            e_wait: begin
                if (cnt_q == '0) begin
                    resp_d  = {resp_data, hdr_payload_q, hdr_size_q, hdr_addr_q, hdr_type_q};
                    state_d = e_resp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            e_resp: begin
                if (mem_if.mem_resp_yumi_i) begin
                    state_d = e_ready;
                    if (resp_is_wr) begin
                        if (wr_count_q != '1) wr_count_d = wr_count_q + 32'd1;
                    end else if (rd_count_q != '1) begin
                        rd_count_d = rd_count_q + 32'd1;
                    end
                end
            end
            default: state_d = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= e_ready;
            cnt_q         <= '0;
            hdr_type_q    <= '0;
            hdr_addr_q    <= '0;
            hdr_size_q    <= '0;
            hdr_payload_q <= '0;
            resp_q        <= '0;
            rd_count_q    <= '0;
            wr_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hdr_type_q    <= hdr_type_d;
            hdr_addr_q    <= hdr_addr_d;
            hdr_size_q    <= hdr_size_d;
            hdr_payload_q <= hdr_payload_d;
            resp_q        <= resp_d;
            rd_count_q    <= rd_count_d;
            wr_count_q    <= wr_count_d;
        end
    end

    // Backing array is deliberately outside reset: committed writes survive a reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[cmd_idx] <= mem_wdata;
    end

    assign mem_if.mem_cmd_ready_o = (state_q == e_ready);
    assign mem_if.mem_resp_v_o    = (state_q == e_resp);
    assign mem_if.mem_resp_o      = resp_q;
    assign rd_count_o             = rd_count_q;
    assign wr_count_o             = wr_count_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cmd_addr[paddr_width_p-1:offset_width_lp+index_width_lp],
                                hdr_addr_q[paddr_width_p-1:offset_width_lp+index_width_lp]};

    assert property (@(posedge clk_i) disable iff (!reset_n_i) cmd_fire |-> (cmd_type <= 4'd3));
endmodule
